// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width: must hold values 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add datapath: operand magnitudes, accumulator and final sign fix-up.
module seq_mult_dp #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 finish,
  input  logic                 signed_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg;

  // Magnitudes of the operands; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits.
  always_comb begin
    a_mag = (signed_en && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_en && b[WIDTH-1]) ? -b : b;
  end

  // One partial product per step; the multiplicand is pre-shifted so no barrel shifter is needed.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
  end

  // Operand capture, iteration, and the result load with conditional negate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      p      <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      neg    <= signed_en & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (finish) begin
        p <= neg ? -acc_next : acc_next;
      end
    end
  end

endmodule

// File: rtl/seq_mult.sv
// Iterative WIDTH x WIDTH multiplier with start/done handshake, signed or unsigned.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_en,
  output logic [2*WIDTH-1:0]   p,
  output logic                 done,
  output logic                 busy
);

  import seq_mult_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          in_run;
  logic          last;

  assign start_ready = (state == IDLE) || (state == DONE);
  assign accept      = start_valid && start_ready;
  assign in_run      = (state == RUN);
  assign last        = in_run && (cnt == CW'(WIDTH - 1));

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (in_run),
    .finish    (last),
    .signed_en (signed_en),
    .a         (a),
    .b         (b),
    .p         (p)
  );

  // Control FSM with iteration counter; done and busy are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
          if (accept) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult at WIDTH=4, 8 and 16.
module tb_seq_mult;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sv;
  logic [2:0]  sr;
  logic [2:0]  dn;
  logic [2:0]  bz;
  logic [15:0] av;
  logic [15:0] bv;
  logic        sgv;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [31:0] pv [3];

  int checks = 0;
  int errors = 0;

  assign pv[0] = {24'd0, p4};
  assign pv[1] = {16'd0, p8};
  assign pv[2] = p16;

  seq_mult #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
    .a(av[3:0]), .b(bv[3:0]), .signed_en(sgv), .p(p4), .done(dn[0]), .busy(bz[0])
  );
  seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
    .a(av[7:0]), .b(bv[7:0]), .signed_en(sgv), .p(p8), .done(dn[1]), .busy(bz[1])
  );
  seq_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr[2]),
    .a(av), .b(bv), .signed_en(sgv), .p(p16), .done(dn[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    bit         sg;
    logic [7:0] p;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer product of the operands interpreted with the chosen signedness.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input bit sg);
    longint xs, ys, pr, one;
    one = 1;
    xs  = longint'(x) & ((one << w) - 1);
    ys  = longint'(y) & ((one << w) - 1);
    if (sg && x[w-1]) xs = xs - (one << w);
    if (sg && y[w-1]) ys = ys - (one << w);
    pr = (xs * ys) & ((one << (2 * w)) - 1);
    return pr[31:0];
  endfunction

  // Issue one request on instance idx, scramble operands during RUN, measure latency and busy.
  task automatic do_op(input int idx, input logic [15:0] aa, input logic [15:0] bb, input bit sg,
                       output logic [31:0] got, output int lat, output int nbusy,
                       output bit extra_done);
    @(negedge clk);
    av = aa; bv = bb; sgv = sg; sv[idx] = 1'b1;
    @(posedge clk); #1;
    sv[idx] = 1'b0;
    lat = 0;
    nbusy = bz[idx] ? 1 : 0;
    while (!dn[idx] && lat < 100) begin
      av = 16'($urandom); bv = 16'($urandom); sgv = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (bz[idx]) nbusy++;
    end
    got = pv[idx];
    @(posedge clk); #1;
    extra_done = dn[idx];
  endtask

  initial begin
    logic [31:0] got;
    int          lat, nbusy, t, t1;
    bit          extra, seen;
    int          w;
    logic [15:0] ra, rb;
    bit          rs;
    logic [31:0] exp;

    tbl[0] = '{4'd3,  4'd5,  1'b0, 8'd15};
    tbl[1] = '{4'd15, 4'd15, 1'b0, 8'd225};
    tbl[2] = '{4'h8,  4'h8,  1'b1, 8'h40};
    tbl[3] = '{4'hD,  4'd5,  1'b1, 8'hF1};
    tbl[4] = '{4'd7,  4'hF,  1'b1, 8'hF9};
    tbl[5] = '{4'd0,  4'd9,  1'b0, 8'd0};
    tbl[6] = '{4'h8,  4'd7,  1'b1, 8'hC8};
    tbl[7] = '{4'hF,  4'd1,  1'b1, 8'hFF};

    rst_n = 1'b0; sv = 3'b000; av = '0; bv = '0; sgv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_p4", pv[0], 32'd0);
    chk("reset_p16", pv[2], 32'd0);
    chk("reset_done", {29'd0, dn}, 32'd0);
    chk("reset_busy", {29'd0, bz}, 32'd0);
    chk("reset_ready", {29'd0, sr}, 32'd7);
    @(negedge clk); rst_n = 1'b1;

    // Directed table at WIDTH=4.
    for (int i = 0; i < 8; i++) begin
      do_op(0, {12'd0, tbl[i].a}, {12'd0, tbl[i].b}, tbl[i].sg, got, lat, nbusy, extra);
      chk($sformatf("tbl%0d_p", i), got, {24'd0, tbl[i].p});
      chk($sformatf("tbl%0d_lat", i), lat, 4);
      chk($sformatf("tbl%0d_busy", i), nbusy, 4);
      chk($sformatf("tbl%0d_pulse", i), {31'd0, extra}, 32'd0);
    end

    // Back-to-back: valid held high, second pair presented mid-RUN and accepted in DONE.
    @(negedge clk);
    av = 16'd3; bv = 16'd5; sgv = 1'b0; sv[0] = 1'b1;
    @(posedge clk); #1;
    av = 16'd15; bv = 16'd15;
    t = 0; t1 = -1;
    while (t < 30) begin
      @(posedge clk); #1;
      t++;
      if (t == 2) begin av = 16'd10; bv = 16'd6; end
      if (dn[0] && t1 < 0) begin
        t1 = t;
        chk("b2b_first_lat", t, 4);
        chk("b2b_first_p", pv[0], 32'd15);
        chk("b2b_ready_in_done", {31'd0, sr[0]}, 32'd1);
      end else if (t1 >= 0 && t == t1 + 1) begin
        sv[0] = 1'b0; av = 16'd13; bv = 16'd13; sgv = 1'b1;
        chk("b2b_second_accepted", {31'd0, bz[0]}, 32'd1);
      end else if (dn[0] && t1 >= 0) begin
        break;
      end
    end
    chk("b2b_gap", t - t1, 5);
    chk("b2b_second_p", pv[0], 32'd60);

    // Reset two cycles into RUN aborts immediately.
    @(negedge clk);
    av = 16'd7; bv = 16'd7; sgv = 1'b0; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_p", pv[0], 32'd0);
    chk("abort_done", {31'd0, dn[0]}, 32'd0);
    chk("abort_busy", {31'd0, bz[0]}, 32'd0);
    chk("abort_ready", {31'd0, sr[0]}, 32'd1);
    @(negedge clk); sv[0] = 1'b1; av = 16'd5; bv = 16'd5;
    @(posedge clk); #1; sv[0] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (dn[0] || bz[0]) seen = 1'b1;
    end
    chk("abort_no_activity", {31'd0, seen}, 32'd0);
    do_op(0, 16'd2, 16'd3, 1'b0, got, lat, nbusy, extra);
    chk("post_reset_p", got, 32'd6);
    chk("post_reset_lat", lat, 4);

    // Exhaustive WIDTH=4 in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          do_op(0, 16'(x), 16'(y), 1'(m), got, lat, nbusy, extra);
          chk($sformatf("sweep_m%0d_%0d_%0d", m, x, y), got, ref_mul(4, 16'(x), 16'(y), 1'(m)));
          chk($sformatf("sweep_lat_m%0d_%0d_%0d", m, x, y), lat, 4);
        end
      end
    end

    // Random regressions at WIDTH=8 and WIDTH=16.
    for (int k = 1; k < 3; k++) begin
      w = (k == 1) ? 8 : 16;
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom_range(0, (1 << w) - 1));
        rb = 16'($urandom_range(0, (1 << w) - 1));
        rs = 1'($urandom_range(0, 1));
        if (n == 0) begin ra = 16'(1 << (w - 1)); rb = ra; rs = 1'b1; end
        if (n == 1) begin ra = 16'((1 << w) - 1); rb = ra; rs = 1'b0; end
        exp = ref_mul(w, ra, rb, rs);
        do_op(k, ra, rb, rs, got, lat, nbusy, extra);
        chk($sformatf("rand_w%0d_%0d_p", w, n), got, exp);
        chk($sformatf("rand_w%0d_%0d_lat", w, n), lat, w);
        chk($sformatf("rand_w%0d_%0d_pulse", w, n), {31'd0, extra}, 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
